alu_32_bit: RTL and testbench

ALU_32_BIT -- requirements
Module: alu_32_bit

---
 rtl/alu_32_bit_pkg.sv | 14 +
 rtl/alu_32_bit_div.sv | 22 ++
 rtl/alu_32_bit.sv | 103 ++++++++++
 tb/tb_alu_32_bit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_32_bit_pkg.sv
// alu_32_bit_pkg: shared opcode constants and default width for the ALU
package alu_32_bit_pkg;
  localparam int N_DEFAULT = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
endpackage

// File: rtl/alu_32_bit_div.sv
// alu_div: combinational signed divider, truncating toward zero, with divide-by-zero and min/-1 exceptions
module alu_div #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         exc
);
  logic by_zero, min_neg1;
  logic [N-1:0] b_safe, q_raw, r_raw;
  assign by_zero = b == '0;
  assign min_neg1 = (a == {1'b1, {(N-1){1'b0}}}) && (&b);
  // Exceptional cases never reach the divider so the simulation model cannot trap
  assign b_safe = (by_zero || min_neg1) ? {{(N-1){1'b0}}, 1'b1} : b;
  assign q_raw = $signed(a) / $signed(b_safe);
  assign r_raw = $signed(a) % $signed(b_safe);
  assign q = by_zero ? '1 : min_neg1 ? a : q_raw;
  assign r = by_zero ? a : min_neg1 ? '0 : r_raw;
  assign exc = by_zero || min_neg1;
endmodule

// File: rtl/alu_32_bit.sv
// alu_32_bit: signed N-bit ALU with one registered output stage and flags
module alu_32_bit
  import alu_32_bit_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   opcode,
  output logic [N-1:0] result,
  output logic [N-1:0] remainder,
  output logic         carry_out,
  output logic         zero,
  output logic         overflow
);
  logic [4:0] sh;
  logic [N:0] add_s, sub_s, sll_w;
  logic signed [N:0] sra_w;
  logic signed [2*N-1:0] a_x, b_x, prod;
  logic [N-1:0] div_q, div_r;
  logic div_exc;
  logic [N-1:0] result_d, result_q, remainder_d, remainder_q;
  logic carry_d, carry_q, zero_d, zero_q, overflow_d, overflow_q;
  assign sh = b[4:0];
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + 1'b1;
  assign a_x = {{N{a[N-1]}}, a};
  assign b_x = {{N{b[N-1]}}, b};
  assign prod = a_x * b_x;
  // Extra guard bit catches the last bit shifted out; it stays 0 for a zero shift
  assign sll_w = {1'b0, a} << sh;
  assign sra_w = $signed({a, 1'b0}) >>> sh;
  alu_div #(.N(N)) u_div (
    .a   (a),
    .b   (b),
    .q   (div_q),
    .r   (div_r),
    .exc (div_exc)
  );
  always_comb begin
    result_d = '0;
    remainder_d = '0;
    carry_d = 1'b0;
    overflow_d = 1'b0;
    case (opcode)
      OP_ADD: begin
        result_d = add_s[N-1:0];
        carry_d = add_s[N];
        overflow_d = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
      end
      OP_SUB: begin
        result_d = sub_s[N-1:0];
        carry_d = sub_s[N];
        overflow_d = (a[N-1] != b[N-1]) && (sub_s[N-1] != a[N-1]);
      end
      OP_MUL: begin
        result_d = prod[N-1:0];
        overflow_d = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
      end
      OP_DIV: begin
        result_d = div_q;
        remainder_d = div_r;
        overflow_d = div_exc;
      end
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_XOR: result_d = a ^ b;
      OP_NOT: result_d = ~a;
      OP_SLL: begin
        result_d = sll_w[N-1:0];
        carry_d = sll_w[N];
      end
      OP_SRA: begin
        result_d = sra_w[N:1];
        carry_d = sra_w[0];
      end
      default: ;
    endcase
    zero_d = result_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      remainder_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q <= result_d;
      remainder_q <= remainder_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      overflow_q <= overflow_d;
    end
  end
  assign result = result_q;
  assign remainder = remainder_q;
  assign carry_out = carry_q;
  assign zero = zero_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_alu_32_bit.sv
// tb_alu_32_bit: directed vectors with a queue scoreboard checked by an independent monitor
module tb_alu_32_bit;
  typedef struct {
    string       name;
    logic [31:0] r;
    logic [31:0] rem;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0] opcode = '0;
  logic [31:0] result, remainder;
  logic carry_out, zero, overflow;
  exp_t sb[$];
  exp_t e;
  int n_pass = 0, n_total = 0;
  alu_32_bit #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .result    (result),
    .remainder (remainder),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if (result === e.r && remainder === e.rem && carry_out === e.c && zero === e.z && overflow === e.v)
        n_pass++;
      else
        $display("FAIL %s: got r=%h rem=%h c=%b z=%b v=%b, want r=%h rem=%h c=%b z=%b v=%b",
                 e.name, result, remainder, carry_out, zero, overflow, e.r, e.rem, e.c, e.z, e.v);
    end
  end
  task automatic drive(input string nm, input logic [3:0] op, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] er, input logic [31:0] erem, input logic ec, input logic ez, input logic ev);
    exp_t x;
    opcode = op;
    a = ai;
    b = bi;
    x.name = nm; x.r = er; x.rem = erem; x.c = ec; x.z = ez; x.v = ev;
    sb.push_back(x);
  endtask
  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] er, input logic [31:0] erem, input logic ec, input logic ez, input logic ev);
    @(negedge clk);
    drive(nm, op, ai, bi, er, erem, ec, ez, ev);
  endtask
  task automatic chk_cleared(input string nm);
    n_total++;
    if ({result, remainder, carry_out, zero, overflow} === '0)
      n_pass++;
    else
      $display("FAIL %s: got r=%h rem=%h c=%b z=%b v=%b, want all zero",
               nm, result, remainder, carry_out, zero, overflow);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 chk_cleared("reset_initial");
    @(negedge clk);
    @(negedge clk);
    drive("release_add", 4'd0, 32'd10, 32'd20, 32'd30, 32'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    issue("add_ovf",   4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 32'd0, 1'b0, 1'b0, 1'b1);
    issue("add_carry", 4'd0, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'd0, 1'b1, 1'b1, 1'b0);
    issue("sub_eq",    4'd1, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    issue("sub_borrow",4'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sub_ovf",   4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b1, 1'b0, 1'b1);
    issue("mul_ovf",   4'd2, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b0, 1'b1);
    issue("mul_neg",   4'd2, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("div_neg",   4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    issue("div_negb",  4'd3, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 1'b0);
    issue("div_zero",  4'd3, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    issue("div_minm1", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0, 1'b1);
    issue("and",       4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("or",        4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("xor",       4'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("not",       4'd7, 32'h0000FFFF, 32'd0, 32'hFFFF0000, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sll1",      4'd8, 32'h80000001, 32'd1, 32'h00000002, 32'd0, 1'b1, 1'b0, 1'b0);
    issue("sll4_zero", 4'd8, 32'h10000000, 32'd4, 32'h00000000, 32'd0, 1'b1, 1'b1, 1'b0);
    issue("sll_b_lo5", 4'd8, 32'h00000001, 32'h21, 32'h00000002, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sra1",      4'd9, 32'h80000003, 32'd1, 32'hC0000001, 32'd0, 1'b1, 1'b0, 1'b0);
    issue("sra31",     4'd9, 32'h80000000, 32'd31, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("op12",      4'd12, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    issue("op15",      4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    issue("sw_add", 4'd0, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sw_sub", 4'd1, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    issue("sw_mul", 4'd2, 32'h7FFFFFFF, 32'd0, 32'h00000000, 32'd0, 1'b0, 1'b1, 1'b0);
    issue("sw_div", 4'd3, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    issue("sw_and", 4'd4, 32'h7FFFFFFF, 32'd0, 32'h00000000, 32'd0, 1'b0, 1'b1, 1'b0);
    issue("sw_or",  4'd5, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sw_xor", 4'd6, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sw_not", 4'd7, 32'h7FFFFFFF, 32'd0, 32'h80000000, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sw_sll", 4'd8, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("sw_sra", 4'd9, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    issue("pre_reset", 4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_cleared("reset_async");
    @(negedge clk);
    opcode = 4'd0;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk);
    #1 chk_cleared("reset_held");
    @(negedge clk);
    drive("release_new", 4'd0, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (sb.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
